// File: rtl/ultrasonic_scheduler.sv
// ultrasonic_scheduler: round-robin trigger/echo controller for a bank of ultrasonic rangers.
// Optional macro USCHED_SYNC_EN adds a two-flop synchronizer per echo line (2 cycles extra latency).
//
// state      | meaning
// -----------+------------------------------------------------------------
// IDLE       | not scheduling; waits for enable
// TRIG       | trigger pulse on the selected sensor for TRIG_CYCLES cycles
// WAIT_RISE  | waiting for a 0->1 echo transition, bounded by ECHO_TIMEOUT
// MEASURE    | echo high; prescaler/cm counting, bounded by ECHO_TIMEOUT
// REPORT     | one-cycle result strobe
// GUARD      | settle time, then advance to the next sensor
module ultrasonic_scheduler #(
   parameter int NUM_SENSORS   = 4,
   parameter int TRIG_CYCLES   = 500,
   parameter int CYCLES_PER_CM = 2900,
   parameter int ECHO_TIMEOUT  = 1250000,
   parameter int MAX_CM        = 400,
   parameter int GUARD_CYCLES  = 3000000,
   parameter int DIST_W        = 9,
   localparam int SW           = $clog2(NUM_SENSORS)
) (
   input  logic                   i_clock,
   input  logic                   i_resetn,
   input  logic                   i_enable,
   input  logic [NUM_SENSORS-1:0] i_echo,
   output logic [NUM_SENSORS-1:0] o_trig,
   output logic                   o_dist_valid,
   output logic [SW-1:0]          o_dist_sensor,
   output logic [DIST_W-1:0]      o_dist_cm,
   output logic                   o_dist_timeout,
   output logic                   o_busy
);

   localparam int TMAX_EG = (ECHO_TIMEOUT > GUARD_CYCLES) ? ECHO_TIMEOUT : GUARD_CYCLES;
   localparam int TMAX    = (TMAX_EG > TRIG_CYCLES) ? TMAX_EG : TRIG_CYCLES;
   localparam int TW      = $clog2(TMAX + 1);
   localparam int PW      = $clog2(CYCLES_PER_CM + 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_TRIG,
      ST_WAIT_RISE,
      ST_MEASURE,
      ST_REPORT,
      ST_GUARD
   } state_t;

   state_t                   r_state;
   state_t                   w_next;
   logic [TW-1:0]            r_timer;
   logic                     w_tc;
   logic [SW-1:0]            r_idx;
   logic [SW-1:0]            w_idx_next;
   logic [PW-1:0]            r_presc;
   logic [DIST_W-1:0]        r_cm;
   logic [DIST_W-1:0]        w_cm_next;
   logic                     w_wrap;
   logic [NUM_SENSORS-1:0]   w_echo_s;
   logic [NUM_SENSORS-1:0]   r_echo_q;
   logic                     w_rise;
   logic                     w_fall;
   logic [NUM_SENSORS-1:0]   r_trig;
   logic                     r_valid;
   logic [SW-1:0]            r_sensor;
   logic [DIST_W-1:0]        r_dist_cm;
   logic                     r_timeout;

`ifdef USCHED_SYNC_EN
   logic [NUM_SENSORS-1:0]   r_sync1;
   logic [NUM_SENSORS-1:0]   r_sync2;

   always_ff @(posedge i_clock or negedge i_resetn) begin
      if (!i_resetn) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= i_echo;
         r_sync2 <= r_sync1;
      end
   end

   assign w_echo_s = r_sync2;
`else
   assign w_echo_s = i_echo;
`endif

   // All lines are tracked so the previous sample is valid the moment idx changes.
   always_ff @(posedge i_clock or negedge i_resetn) begin
      if (!i_resetn) r_echo_q <= '0;
      else           r_echo_q <= w_echo_s;
   end

   assign w_rise    = w_echo_s[r_idx] & ~r_echo_q[r_idx];
   assign w_fall    = ~w_echo_s[r_idx] & r_echo_q[r_idx];
   assign w_tc      = (r_timer == '0);
   assign w_wrap    = (r_presc == PW'(CYCLES_PER_CM - 1));
   assign w_cm_next = (w_wrap && (r_cm < DIST_W'(MAX_CM))) ? r_cm + DIST_W'(1) : r_cm;

   always_ff @(posedge i_clock or negedge i_resetn) begin
      if (!i_resetn) r_state <= ST_IDLE;
      else           r_state <= w_next;
   end

   // Timeouts take priority over echo edges in the same cycle.
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:      if (i_enable) w_next = ST_TRIG;
         ST_TRIG:      if (w_tc) w_next = ST_WAIT_RISE;
         ST_WAIT_RISE: begin
            if (w_tc)        w_next = ST_REPORT;
            else if (w_rise) w_next = ST_MEASURE;
         end
         ST_MEASURE:   if (w_tc || w_fall) w_next = ST_REPORT;
         ST_REPORT:    w_next = ST_GUARD;
         ST_GUARD:     if (w_tc) w_next = i_enable ? ST_TRIG : ST_IDLE;
         default:      w_next = ST_IDLE;
      endcase
   end

   always_comb begin
      w_idx_next = r_idx;
      if (r_state == ST_GUARD && w_tc)
         w_idx_next = (r_idx == SW'(NUM_SENSORS - 1)) ? '0 : r_idx + SW'(1);
   end

   // Down-counter loaded with (duration-1) on state entry; terminal count at zero.
   always_ff @(posedge i_clock or negedge i_resetn) begin
      if (!i_resetn) begin
         r_timer <= '0;
      end else if (w_next != r_state) begin
         case (w_next)
            ST_TRIG:                  r_timer <= TW'(TRIG_CYCLES - 1);
            ST_WAIT_RISE, ST_MEASURE: r_timer <= TW'(ECHO_TIMEOUT - 1);
            ST_GUARD:                 r_timer <= TW'(GUARD_CYCLES - 1);
            default:                  r_timer <= '0;
         endcase
      end else if (!w_tc) begin
         r_timer <= r_timer - TW'(1);
      end
   end

   always_ff @(posedge i_clock or negedge i_resetn) begin
      if (!i_resetn) begin
         r_presc <= '0;
         r_cm    <= '0;
      end else if (w_next == ST_MEASURE && r_state != ST_MEASURE) begin
         r_presc <= '0;
         r_cm    <= '0;
      end else if (r_state == ST_MEASURE) begin
         r_presc <= w_wrap ? '0 : r_presc + PW'(1);
         r_cm    <= w_cm_next;
      end
   end

   always_ff @(posedge i_clock or negedge i_resetn) begin
      if (!i_resetn) begin
         r_idx <= '0;
      end else begin
         r_idx <= w_idx_next;
      end
   end

   always_ff @(posedge i_clock or negedge i_resetn) begin
      if (!i_resetn) begin
         r_trig <= '0;
      end else begin
         for (int i = 0; i < NUM_SENSORS; i++)
            r_trig[i] <= (w_next == ST_TRIG) && (w_idx_next == SW'(i));
      end
   end

   // Result fields load on REPORT entry so they are valid during the strobe cycle.
   always_ff @(posedge i_clock or negedge i_resetn) begin
      if (!i_resetn) begin
         r_valid   <= 1'b0;
         r_sensor  <= '0;
         r_dist_cm <= '0;
         r_timeout <= 1'b0;
      end else begin
         r_valid <= (w_next == ST_REPORT);
         if (w_next == ST_REPORT) begin
            r_sensor <= r_idx;
            if (w_tc) begin
               r_dist_cm <= DIST_W'(MAX_CM);
               r_timeout <= 1'b1;
            end else begin
               r_dist_cm <= w_cm_next;
               r_timeout <= 1'b0;
            end
         end
      end
   end

   assign o_trig         = r_trig;
   assign o_dist_valid   = r_valid;
   assign o_dist_sensor  = r_sensor;
   assign o_dist_cm      = r_dist_cm;
   assign o_dist_timeout = r_timeout;
   assign o_busy         = (r_state != ST_IDLE);

endmodule

// File: tb/tb_ultrasonic_scheduler.sv
// Testbench for ultrasonic_scheduler: directed and randomized echo scenarios against a timing model.
`timescale 1ns/1ps
module tb_ultrasonic_scheduler;

   localparam int NS   = 2;
   localparam int TC   = 4;
   localparam int CPC  = 10;
   localparam int TO   = 200;
   localparam int MAXC = 15;
   localparam int GC   = 20;
   localparam int DW   = 9;
`ifdef USCHED_SYNC_EN
   localparam int LAT  = 2;
`else
   localparam int LAT  = 0;
`endif

   logic          clk = 1'b0;
   logic          rstn;
   logic          en;
   logic [NS-1:0] echo;
   logic [NS-1:0] trig;
   logic          dv;
   logic [0:0]    ds;
   logic [DW-1:0] dcm;
   logic          dto;
   logic          busy;

   int n_checks = 0;
   int n_fail   = 0;
   int exp_idx  = 0;

   always #5 clk = ~clk;

   ultrasonic_scheduler #(
      .NUM_SENSORS(NS), .TRIG_CYCLES(TC), .CYCLES_PER_CM(CPC), .ECHO_TIMEOUT(TO),
      .MAX_CM(MAXC), .GUARD_CYCLES(GC), .DIST_W(DW)
   ) dut (
      .i_clock(clk), .i_resetn(rstn), .i_enable(en), .i_echo(echo),
      .o_trig(trig), .o_dist_valid(dv), .o_dist_sensor(ds), .o_dist_cm(dcm),
      .o_dist_timeout(dto), .o_busy(busy)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference: offsets are clock edges after WAIT_RISE entry; raw echo rises at t_r, high w cycles.
   function automatic void model(input int stale_len, input int d, input int w,
                                 output int off, output int cm, output int to);
      int j;
      if (w <= 0) begin
         off = TO; cm = MAXC; to = 1;
         return;
      end
      j = stale_len + d + 1 + LAT;
      if (j >= TO) begin
         off = TO; cm = MAXC; to = 1;
      end else if (w >= TO) begin
         off = j + TO; cm = MAXC; to = 1;
      end else begin
         off = j + w; cm = (w / CPC > MAXC) ? MAXC : w / CPC; to = 0;
      end
   endfunction

   // Drives one measurement on sensor s and returns what was observed.
   task automatic run_meas(input int s, input int stale_len, input int d, input int w, input int drop_at,
                           output int trig_len, output int other_hi, output int off,
                           output int v_sensor, output int v_cm, output int v_to, output int v_next,
                           output bit ok);
      logic [NS-1:0] sel;
      int n;
      int t;
      int tr;
      sel = NS'(1) << s;
      ok = 1; trig_len = 0; other_hi = 0; off = -1;
      v_sensor = -1; v_cm = -1; v_to = -1; v_next = -1;
      n = 0;
      while (trig[s] !== 1'b1 && n < 400) begin
         step();
         n++;
         if ((trig & ~sel) != '0) other_hi++;
      end
      if (trig[s] !== 1'b1) begin
         ok = 0;
         return;
      end
      if (stale_len > 0) echo[s] = 1'b1;
      while (trig[s] === 1'b1 && trig_len < 100) begin
         if ((trig & ~sel) != '0) other_hi++;
         trig_len++;
         step();
      end
      tr = stale_len + d;
      t  = 0;
      while (t < 2 * TO + 50) begin
         echo[s]     = (t < stale_len) || (w > 0 && t >= tr && t < tr + w);
         echo[1 - s] = 1'($urandom_range(0, 1));
         if (t == drop_at) en = 1'b0;
         step();
         t++;
         if ((trig & ~sel) != '0) other_hi++;
         if (dv === 1'b1) begin
            off = t; v_sensor = int'(ds); v_cm = int'(dcm); v_to = int'(dto);
            break;
         end
      end
      echo = '0;
      if (off < 0) ok = 0;
      step();
      v_next = int'(dv);
   endtask

   task automatic test_reset();
      rstn = 1'b0; en = 1'b0; echo = '0;
      repeat (3) @(posedge clk);
      #1;
      n_checks++; if (trig !== '0)  begin n_fail++; $display("FAIL reset_trig: got %b expected 00", trig); end
      n_checks++; if (dv !== 1'b0)  begin n_fail++; $display("FAIL reset_valid: got %b expected 0", dv); end
      n_checks++; if (ds !== 1'b0)  begin n_fail++; $display("FAIL reset_sensor: got %0d expected 0", ds); end
      n_checks++; if (dcm !== '0)   begin n_fail++; $display("FAIL reset_cm: got %0d expected 0", dcm); end
      n_checks++; if (dto !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %b expected 0", dto); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
      rstn = 1'b1;
      repeat (3) step();
      n_checks++; if (busy !== 1'b0 || trig !== '0)
         begin n_fail++; $display("FAIL idle_disabled: busy=%b trig=%b expected 0/00", busy, trig); end
   endtask

   task automatic test_basic();
      int tl, oh, off, vs, vc, vt, vn, e_off, e_cm, e_to;
      bit ok;
      en = 1'b1;
      step();
      n_checks++; if (trig !== 2'b01) begin n_fail++; $display("FAIL enable_to_trig: got %b expected 01", trig); end
      n_checks++; if (busy !== 1'b1)  begin n_fail++; $display("FAIL busy_trig: got %b expected 1", busy); end
      run_meas(0, 0, 3, 57, -1, tl, oh, off, vs, vc, vt, vn, ok);
      model(0, 3, 57, e_off, e_cm, e_to);
      n_checks++; if (!ok)          begin n_fail++; $display("FAIL basic_progress: no result within budget"); end
      n_checks++; if (tl !== TC)    begin n_fail++; $display("FAIL basic_trig_len: got %0d expected %0d", tl, TC); end
      n_checks++; if (oh !== 0)     begin n_fail++; $display("FAIL basic_other_trig: got %0d expected 0", oh); end
      n_checks++; if (off !== e_off) begin n_fail++; $display("FAIL basic_latency: got %0d expected %0d", off, e_off); end
      n_checks++; if (vs !== 0)     begin n_fail++; $display("FAIL basic_sensor: got %0d expected 0", vs); end
      n_checks++; if (vc !== e_cm)  begin n_fail++; $display("FAIL basic_cm: got %0d expected %0d", vc, e_cm); end
      n_checks++; if (vt !== e_to)  begin n_fail++; $display("FAIL basic_timeout: got %0d expected %0d", vt, e_to); end
      n_checks++; if (vn !== 0)     begin n_fail++; $display("FAIL basic_strobe_len: got %0d expected 0", vn); end
      n_checks++; if (int'(dcm) !== e_cm) begin n_fail++; $display("FAIL basic_cm_hold: got %0d expected %0d", dcm, e_cm); end
      exp_idx = 1;
   endtask

   task automatic test_rise_timeout();
      int tl, oh, off, vs, vc, vt, vn, n;
      bit ok;
      run_meas(1, 0, 0, 0, -1, tl, oh, off, vs, vc, vt, vn, ok);
      n_checks++; if (!ok)         begin n_fail++; $display("FAIL rto_progress: no result within budget"); end
      n_checks++; if (off !== TO)  begin n_fail++; $display("FAIL rto_latency: got %0d expected %0d", off, TO); end
      n_checks++; if (vs !== 1)    begin n_fail++; $display("FAIL rto_sensor: got %0d expected 1", vs); end
      n_checks++; if (vc !== MAXC) begin n_fail++; $display("FAIL rto_cm: got %0d expected %0d", vc, MAXC); end
      n_checks++; if (vt !== 1)    begin n_fail++; $display("FAIL rto_timeout: got %0d expected 1", vt); end
      n = 1;
      while (trig === '0 && n < 100) begin
         step();
         n++;
      end
      n_checks++; if (n !== GC + 1)   begin n_fail++; $display("FAIL guard_spacing: got %0d expected %0d", n, GC + 1); end
      n_checks++; if (trig !== 2'b01) begin n_fail++; $display("FAIL idx_wrap: got %b expected 01", trig); end
      exp_idx = 0;
   endtask

   task automatic test_table();
      int st[9] = '{0, 0, 4, 0, 0, 0, 0, 0, 0};
      int dd[9] = '{2, 5, 3, 1, 1, 0, 0, 198, 199};
      int ww[9] = '{180, 250, 30, 9, 10, 199, 200, 5, 5};
      int tl, oh, off, vs, vc, vt, vn, e_off, e_cm, e_to;
      bit ok;
      for (int k = 0; k < 9; k++) begin
         run_meas(exp_idx, st[k], dd[k], ww[k], -1, tl, oh, off, vs, vc, vt, vn, ok);
         model(st[k], dd[k], ww[k], e_off, e_cm, e_to);
         n_checks++; if (!ok || off !== e_off)
            begin n_fail++; $display("FAIL table%0d_latency: got %0d expected %0d", k, off, e_off); end
         n_checks++; if (vs !== exp_idx) begin n_fail++; $display("FAIL table%0d_sensor: got %0d expected %0d", k, vs, exp_idx); end
         n_checks++; if (vc !== e_cm)    begin n_fail++; $display("FAIL table%0d_cm: got %0d expected %0d", k, vc, e_cm); end
         n_checks++; if (vt !== e_to)    begin n_fail++; $display("FAIL table%0d_timeout: got %0d expected %0d", k, vt, e_to); end
         n_checks++; if (tl !== TC || oh !== 0)
            begin n_fail++; $display("FAIL table%0d_trig: len %0d other %0d expected %0d/0", k, tl, oh, TC); end
         exp_idx = (exp_idx + 1) % NS;
      end
   endtask

   task automatic test_random();
      int s_len, d, w, tl, oh, off, vs, vc, vt, vn, e_off, e_cm, e_to;
      bit ok;
      for (int k = 0; k < 5; k++) begin
         s_len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : 0;
         d     = int'($urandom_range(1, 20));
         w     = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 260));
         run_meas(exp_idx, s_len, d, w, -1, tl, oh, off, vs, vc, vt, vn, ok);
         model(s_len, d, w, e_off, e_cm, e_to);
         n_checks++; if (!ok || off !== e_off)
            begin n_fail++; $display("FAIL rand%0d_latency: stale %0d d %0d w %0d got %0d expected %0d", k, s_len, d, w, off, e_off); end
         n_checks++; if (vs !== exp_idx || vc !== e_cm || vt !== e_to)
            begin n_fail++; $display("FAIL rand%0d_result: w %0d got s%0d cm%0d to%0d expected s%0d cm%0d to%0d",
                                     k, w, vs, vc, vt, exp_idx, e_cm, e_to); end
         exp_idx = (exp_idx + 1) % NS;
      end
   endtask

   task automatic test_enable_drop();
      int tl, oh, off, vs, vc, vt, vn, e_off, e_cm, e_to, bad, s;
      bit ok;
      s = exp_idx;
      run_meas(s, 0, 2, 45, 10, tl, oh, off, vs, vc, vt, vn, ok);
      model(0, 2, 45, e_off, e_cm, e_to);
      n_checks++; if (!ok || off !== e_off)
         begin n_fail++; $display("FAIL drop_latency: got %0d expected %0d", off, e_off); end
      n_checks++; if (vc !== e_cm || vt !== e_to)
         begin n_fail++; $display("FAIL drop_result: got cm%0d to%0d expected cm%0d to%0d", vc, vt, e_cm, e_to); end
      repeat (GC - 1) step();
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL drop_guard_busy: got %b expected 1", busy); end
      step();
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL drop_idle_busy: got %b expected 0", busy); end
      bad = 0;
      for (int k = 0; k < 30; k++) begin
         step();
         if (trig !== '0 || busy !== 1'b0) bad++;
      end
      n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL drop_no_trig: got %0d active cycles expected 0", bad); end
      exp_idx = (s + 1) % NS;
      en = 1'b1;
      step();
      n_checks++; if (trig !== (NS'(1) << exp_idx))
         begin n_fail++; $display("FAIL drop_resume_idx: got %b expected %b", trig, NS'(1) << exp_idx); end
   endtask

   task automatic test_reset_mid();
      int tl, oh, off, vs, vc, vt, vn, e_off, e_cm, e_to;
      bit ok;
      step();
      #2 rstn = 1'b0;
      #1;
      n_checks++; if (trig !== '0) begin n_fail++; $display("FAIL async_trig: got %b expected 00", trig); end
      n_checks++; if (dv !== 1'b0 || ds !== 1'b0 || dcm !== '0 || dto !== 1'b0 || busy !== 1'b0)
         begin n_fail++; $display("FAIL async_outputs: dv%b s%0d cm%0d to%b busy%b expected all 0", dv, ds, dcm, dto, busy); end
      #1 rstn = 1'b1;
      step();
      n_checks++; if (trig !== 2'b01) begin n_fail++; $display("FAIL restart_trig: got %b expected 01", trig); end
      run_meas(0, 0, 1, 25, -1, tl, oh, off, vs, vc, vt, vn, ok);
      model(0, 1, 25, e_off, e_cm, e_to);
      n_checks++; if (!ok || tl !== TC) begin n_fail++; $display("FAIL restart_trig_len: got %0d expected %0d", tl, TC); end
      n_checks++; if (vs !== 0 || vc !== e_cm || vt !== e_to)
         begin n_fail++; $display("FAIL restart_result: got s%0d cm%0d to%0d expected s0 cm%0d to%0d", vs, vc, vt, e_cm, e_to); end
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic();
      test_rise_timeout();
      test_table();
      test_random();
      test_enable_drop();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
